// File: rtl/scan_test_ctrl_pkg.sv
// scan_test_ctrl_pkg: shared FSM encoding and default sizing for the scan tester
package scan_test_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;
  localparam int DEF_CHAIN_LEN = 10;
  localparam int DEF_CNT_W = 6;
endpackage

// File: rtl/scan_test_ctrl_if.sv
// scan_test_ctrl_if: pattern-source request and result bus of the scan tester
interface scan_test_ctrl_if import scan_test_ctrl_pkg::*; #(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CNT_W = DEF_CNT_W
) ();
  logic start;
  logic [CHAIN_LEN-1:0] pat_a, pat_b, exp_a, exp_b, mask_a, mask_b, resp_a, resp_b;
  logic busy, done, fail;
  logic [CNT_W-1:0] mismatch_cnt;
  modport master (
    output start, pat_a, pat_b, exp_a, exp_b, mask_a, mask_b,
    input  busy, done, resp_a, resp_b, fail, mismatch_cnt
  );
  modport slave (
    input  start, pat_a, pat_b, exp_a, exp_b, mask_a, mask_b,
    output busy, done, resp_a, resp_b, fail, mismatch_cnt
  );
endinterface

// File: rtl/scan_test_ctrl_chain_port.sv
// scan_chain_port: one chain's MSB-first loader, LSB-side unloader and masked compare
module scan_chain_port import scan_test_ctrl_pkg::*; #(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift_in,
  input  logic                 shift_out,
  input  logic [CHAIN_LEN-1:0] pat,
  input  logic [CHAIN_LEN-1:0] exp_v,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 so,
  output logic                 si,
  output logic [CHAIN_LEN-1:0] resp,
  output logic [CHAIN_LEN-1:0] diff
);
  logic [CHAIN_LEN-1:0] ld_q, ld_d, exp_q, exp_d, mask_q, mask_d, res_q, res_d;
  always_comb begin
    ld_d = load ? pat : shift_in ? {ld_q[CHAIN_LEN-2:0], 1'b0} : ld_q;
    exp_d = load ? exp_v : exp_q;
    mask_d = load ? mask : mask_q;
    res_d = load ? '0 : shift_out ? {res_q[CHAIN_LEN-2:0], so} : res_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_q <= '0;
      exp_q <= '0;
      mask_q <= '0;
      res_q <= '0;
    end else begin
      ld_q <= ld_d;
      exp_q <= exp_d;
      mask_q <= mask_d;
      res_q <= res_d;
    end
  end
  assign si = ld_q[CHAIN_LEN-1];
  assign resp = res_q;
  assign diff = (res_d ^ exp_q) & mask_q;
endmodule

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: two-chain scan load/capture/unload tester with masked compare
module scan_test_ctrl import scan_test_ctrl_pkg::*; #(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  scan_test_ctrl_if.slave bus,
  input  logic            so1,
  input  logic            so2,
  output logic            si1,
  output logic            si2,
  output logic            se
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, mm_q, mm_d, pop;
  logic se_q, se_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [CHAIN_LEN-1:0] diff_a, diff_b;
  logic load, last, sh_in, sh_out;
  assign load = state_q == IDLE && bus.start;
  assign last = cnt_q == CNT_W'(CHAIN_LEN - 1);
  assign sh_in = state_q == SHIFT_IN;
  assign sh_out = state_q == SHIFT_OUT;
  scan_chain_port #(.CHAIN_LEN(CHAIN_LEN)) u_a (
    .clk(clk), .reset(reset), .load(load), .shift_in(sh_in), .shift_out(sh_out),
    .pat(bus.pat_a), .exp_v(bus.exp_a), .mask(bus.mask_a), .so(so1),
    .si(si1), .resp(bus.resp_a), .diff(diff_a)
  );
  scan_chain_port #(.CHAIN_LEN(CHAIN_LEN)) u_b (
    .clk(clk), .reset(reset), .load(load), .shift_in(sh_in), .shift_out(sh_out),
    .pat(bus.pat_b), .exp_v(bus.exp_b), .mask(bus.mask_b), .so(so2),
    .si(si2), .resp(bus.resp_b), .diff(diff_b)
  );
  always_comb begin
    pop = '0;
    for (int i = 0; i < CHAIN_LEN; i++) pop = pop + CNT_W'(diff_a[i]) + CNT_W'(diff_b[i]);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    se_d = se_q;
    busy_d = busy_q;
    done_d = 1'b0;
    fail_d = fail_q;
    mm_d = mm_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT_IN;
        cnt_d = '0;
        se_d = 1'b1;
        busy_d = 1'b1;
        fail_d = 1'b0;
        mm_d = '0;
      end
      SHIFT_IN: begin
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        state_d = last ? CAPTURE : SHIFT_IN;
        se_d = !last;
      end
      CAPTURE: begin
        state_d = SHIFT_OUT;
        se_d = 1'b1;
      end
      SHIFT_OUT: begin
        cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        state_d = last ? DONE : SHIFT_OUT;
        se_d = !last;
        done_d = last;
        fail_d = last ? |{diff_a, diff_b} : fail_q;
        mm_d = last ? pop : mm_q;
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      se_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      mm_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      se_q <= se_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fail_q <= fail_d;
      mm_q <= mm_d;
    end
  end
  assign se = se_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.fail = fail_q;
  assign bus.mismatch_cnt = mm_q;
endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb_scan_test_ctrl: directed scan-tester bench checked against a pattern-level model
module tb_scan_test_ctrl;
  localparam int N = 10;
  localparam int W = 6;
  localparam logic [N-1:0] BIT3 = 10'h008;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic so1, so2, si1, si2, se;
  logic stuck3 = 1'b0;
  logic const1 = 1'b0;
  logic [N-1:0] chain_a, chain_b;
  int vectors = 0, miscompares = 0, tick = 0, t0 = 0, t_first = 0, se_hi = 0, si_hi = 0, dcyc = 0;
  int c = -1;
  logic [N-1:0] m_pa = '0, m_pb = '0, m_ea = '0, m_eb = '0, m_ma = '0, m_mb = '0;
  logic [N-1:0] m_ra = '0, m_rb = '0, cap_a, cap_b;
  logic m_fail = 1'b0;
  int m_cnt = 0;
  bit m_valid = 1'b1;
  bit ld_ph, ul_ph;
  scan_test_ctrl_if #(.CHAIN_LEN(N), .CNT_W(W)) bus ();
  scan_test_ctrl #(.CHAIN_LEN(N), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .so1(so1), .so2(so2), .si1(si1), .si2(si2), .se(se)
  );
  always #5 clk = ~clk;
  always @(posedge clk) tick++;
  always @(posedge clk) begin
    chain_a <= se ? {chain_a[N-2:0], si1} : ~chain_a & (stuck3 ? ~BIT3 : '1);
    chain_b <= se ? {chain_b[N-2:0], si2} : ~chain_b;
  end
  assign so1 = const1 ? 1'b1 : chain_a[N-1];
  assign so2 = const1 ? 1'b1 : chain_b[N-1];
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      c = -1;
      m_ra = '0;
      m_rb = '0;
      m_fail = 1'b0;
      m_cnt = 0;
      m_valid = 1'b1;
    end else if (c < 0) begin
      if (bus.start) begin
        c = 1;
        m_pa = bus.pat_a;
        m_pb = bus.pat_b;
        m_ea = bus.exp_a;
        m_eb = bus.exp_b;
        m_ma = bus.mask_a;
        m_mb = bus.mask_b;
        m_valid = 1'b0;
      end
    end else if (c == 2 * N + 2) begin
      c = -1;
    end else begin
      c++;
      if (c == 2 * N + 2) begin
        cap_a = const1 ? '1 : ~m_pa & (stuck3 ? ~BIT3 : '1);
        cap_b = const1 ? '1 : ~m_pb;
        m_ra = cap_a;
        m_rb = cap_b;
        m_cnt = $countones((cap_a ^ m_ea) & m_ma) + $countones((cap_b ^ m_eb) & m_mb);
        m_fail = m_cnt != 0;
        m_valid = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    ld_ph = c >= 1 && c <= N;
    ul_ph = c >= N + 2 && c <= 2 * N + 1;
    chk("se", se, ld_ph || ul_ph);
    chk("si1", si1, ld_ph ? m_pa[N-c] : 1'b0);
    chk("si2", si2, ld_ph ? m_pb[N-c] : 1'b0);
    chk("busy", bus.busy, c >= 1 && c <= 2 * N + 2);
    chk("done", bus.done, c == 2 * N + 2);
    if (m_valid) begin
      chk("resp_a", bus.resp_a, m_ra);
      chk("resp_b", bus.resp_b, m_rb);
      chk("fail", bus.fail, m_fail);
      chk("mismatch_cnt", bus.mismatch_cnt, m_cnt);
    end
  end
  task automatic run(input logic [N-1:0] pa, pb, ea, eb, ma, mb, input int p1, p2);
    int cyc;
    bus.pat_a = pa;
    bus.pat_b = pb;
    bus.exp_a = ea;
    bus.exp_b = eb;
    bus.mask_a = ma;
    bus.mask_b = mb;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    t0 = tick;
    bus.pat_a = ~pa;
    bus.pat_b = ~pb;
    bus.exp_a = ~ea;
    bus.exp_b = ~eb;
    bus.mask_a = ~ma;
    bus.mask_b = ~mb;
    dcyc = -1;
    se_hi = 0;
    si_hi = 0;
    for (int i = 0; i < 60; i++) begin
      cyc = tick - t0 + 1;
      bus.start = cyc == p1 || cyc == p2;
      se_hi += (se === 1'b1) ? 1 : 0;
      si_hi += (si1 === 1'b1) ? 1 : 0;
      if (bus.done === 1'b1) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.pat_a = '0;
    bus.pat_b = '0;
    bus.exp_a = '0;
    bus.exp_b = '0;
    bus.mask_a = '0;
    bus.mask_b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_se", se, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_resp_a", bus.resp_a, 0);
    chk("rst_cnt", bus.mismatch_cnt, 0);
    step();
    run(10'h2A5, 10'h15A, 10'h15A, 10'h2A5, '1, '1, 0, 0);
    chk("t1_latency", dcyc, 22);
    chk("t1_resp_a", bus.resp_a, 10'h15A);
    chk("t1_resp_b", bus.resp_b, 10'h2A5);
    chk("t1_fail", bus.fail, 0);
    chk("t1_cnt", bus.mismatch_cnt, 0);
    step();
    chk("t1_idle_busy", bus.busy, 0);
    stuck3 = 1'b1;
    run(10'h2A5, 10'h15A, 10'h15A, 10'h2A5, '1, '1, 0, 0);
    chk("t2_resp_a", bus.resp_a, 10'h152);
    chk("t2_fail", bus.fail, 1);
    chk("t2_cnt", bus.mismatch_cnt, 1);
    step();
    run(10'h2A5, 10'h15A, 10'h15A, 10'h2A5, 10'h3F7, '1, 0, 0);
    chk("t2m_fail", bus.fail, 0);
    chk("t2m_cnt", bus.mismatch_cnt, 0);
    step();
    stuck3 = 1'b0;
    const1 = 1'b1;
    run(10'h2A5, 10'h15A, '0, '0, '1, '1, 0, 0);
    chk("t3_resp_a", bus.resp_a, 10'h3FF);
    chk("t3_resp_b", bus.resp_b, 10'h3FF);
    chk("t3_fail", bus.fail, 1);
    chk("t3_cnt", bus.mismatch_cnt, 20);
    step();
    const1 = 1'b0;
    run(10'h200, 10'h000, 10'h1FF, 10'h3FF, '1, '1, 0, 0);
    chk("t4_latency", dcyc, 22);
    chk("t4_se_cycles", se_hi, 20);
    chk("t4_si1_cycles", si_hi, 1);
    chk("t4_done_se", se, 0);
    chk("t4_resp_a", bus.resp_a, 10'h1FF);
    step();
    run(10'h2A5, 10'h15A, 10'h15A, 10'h2A5, '1, '1, 5, 22);
    t_first = t0;
    chk("t5_first_latency", dcyc, 22);
    step();
    chk("t5_gap_busy", bus.busy, 0);
    chk("t5_gap_done", bus.done, 0);
    run(10'h15A, 10'h2A5, 10'h2A5, 10'h15A, '1, '1, 0, 0);
    chk("t5_second_done_cycle", tick - t_first + 1, 45);
    chk("t5_resp_a", bus.resp_a, 10'h2A5);
    step();
    bus.pat_a = 10'h2A5;
    bus.pat_b = 10'h15A;
    bus.exp_a = 10'h15A;
    bus.exp_b = 10'h2A5;
    bus.mask_a = '1;
    bus.mask_b = '1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (13) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t6_se", se, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_resp_a", bus.resp_a, 0);
    chk("t6_resp_b", bus.resp_b, 0);
    #1 reset = 1'b0;
    step();
    run(10'h2A5, 10'h15A, 10'h15A, 10'h2A5, '1, '1, 0, 0);
    chk("t6_rerun_latency", dcyc, 22);
    chk("t6_rerun_resp_a", bus.resp_a, 10'h15A);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
- On-chip scan tester that drives the two-chain scan interface (si1/si2/se in, so1/so2 out) of the DFT datapath.
- Per pattern: serially loads two chains, issues one capture cycle, unloads the responses and compares them against masked expected values.
- Sits between a pattern source (BIST sequencer or test bus) and the scan ports of the registered pipeline.

Parameters:
CHAIN_LEN, 10, flops per scan chain (both chains equal length); legal range 2..32
CNT_W, 6, width of the shift counter and mismatch counter; must be ≥ clog2(2*CHAIN_LEN+1)

Ports:
clk  input  1  rising-edge clock shared with the chains under test
reset  input  1  asynchronous, active-high reset
start  input  1  request a pattern; accepted only in IDLE
pat_a  input  CHAIN_LEN  stimulus for chain A; bit i lands in flop i (flop 0 nearest si1)
pat_b  input  CHAIN_LEN  stimulus for chain B, same ordering, driven on si2
exp_a  input  CHAIN_LEN  expected captured values, chain A
exp_b  input  CHAIN_LEN  expected captured values, chain B
mask_a  input  CHAIN_LEN  1 = compare this bit, 0 = don't-care
mask_b  input  CHAIN_LEN  same as mask_a, for chain B
so1  input  1  scan out, chain A (last flop q)
so2  input  1  scan out, chain B
si1  output  1  scan in, chain A, registered
si2  output  1  scan in, chain B, registered
se  output  1  scan enable, registered
busy  output  1  high from accept until DONE, inclusive
done  output  1  one-cycle pulse; results valid this cycle and held until the next accept
resp_a  output  CHAIN_LEN  unloaded response, chain A (bit i = flop i)
resp_b  output  CHAIN_LEN  unloaded response, chain B
fail  output  1  at least one masked mismatch
mismatch_cnt  output  CNT_W  number of masked mismatching bits over both chains

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - si1, si2, se, busy, done, fail = 0.
  - resp_a, resp_b, mismatch_cnt = 0.
  - Latched pattern registers cleared.
- All outputs are registered. Cycle 0 is the edge on which start is sampled high in IDLE.
- On accept:
  - pat, exp and mask inputs are latched.
  - Inputs may change afterwards without effect.
  - start is ignored in every state other than IDLE.
- FSM states: IDLE → SHIFT_IN → CAPTURE → SHIFT_OUT → DONE → IDLE.
- SHIFT_IN, cycles 1..N (N = CHAIN_LEN):
  - se = 1.
  - In cycle j: si1 = pat_a[N-j], si2 = pat_b[N-j]. The MSB is shifted first.
  - After the N-th edge, flop i holds pat[i].
- CAPTURE, cycle N+1: se = 0, si = 0. Exactly one functional capture edge.
- SHIFT_OUT, cycles N+1+k for k = 1..N:
  - se = 1, si = 0.
  - At the closing edge of each cycle, so1 → resp_a[N-k] and so2 → resp_b[N-k].
  - The first sample is taken before any shift, so it is flop N-1's captured value.
- DONE, cycle 2N+2:
  - se = 0, done = 1, busy = 1.
  - resp_a, resp_b, fail and mismatch_cnt are valid.
  - Next cycle: IDLE, busy = 0.
- Latency: start to done = 2N+2 cycles. No overlap between patterns; back-to-back start is accepted in the cycle after DONE.
- Compare: computed in the same edge that registers the final sample, so results are valid when done is high.
  - fail = |((resp_a^exp_a)&mask_a) | |((resp_b^exp_b)&mask_b).
  - mismatch_cnt = popcount of both masked XOR vectors; max 2N, no overflow by the CNT_W rule.
- All-zero masks: fail = 0 and mismatch_cnt = 0 regardless of responses.
- Reset asserted mid-pattern:
  - Immediate return to IDLE, se drops to 0, no done pulse.
  - Partial response is discarded (cleared).
- X on so1/so2: propagates to resp, and to fail only if the bit is masked.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE = 0, SHIFT_IN = 1, CAPTURE = 2, SHIFT_OUT = 3, DONE = 4; 3-bit encoding.
  - default CHAIN_LEN.
- One sub-module is natural: scan_chain_port. It holds one chain's load shift register (MSB-first onto si), unload shift register (so into LSB side) and masked XOR compare vector. It is instantiated twice, for chains A and B.
- The FSM, counter and popcount stay in the top.

Test Plan:
1. N=10; pat_a = 10'h2A5, pat_b = 10'h15A; so1/so2 looped to a behavioural 10-flop chain model with capture D = ~Q; exp = ~pat; masks all-ones → done at cycle 22, resp_a = 10'h15A, resp_b = 10'h2A5, fail = 0, mismatch_cnt = 0.
2. Same as 1 but chain-A model flop 3 stuck-at-0 → resp_a[3] = 0, fail = 1, mismatch_cnt = 1; with mask_a[3] = 0 instead → fail = 0, mismatch_cnt = 0.
3. so1 = so2 = 1 constant, exp = 0, masks all-ones → resp = 10'h3FF both, mismatch_cnt = 20, fail = 1.
4. Check se/si waveform for pat_a = 10'h200: se high cycles 1–10, low cycle 11, high 12–21, low 22; si1 = 1 only in cycle 1.
5. start pulsed again at cycle 5 and cycle 22 → both ignored (no second done); start at cycle 23 → new pattern accepted, done at cycle 45.
6. Reset asserted at cycle 14 (mid SHIFT_OUT) → se, busy and done drop to 0 immediately; resp = 0; no done pulse; next start runs normally.
